// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared constants and controller state encoding for the 32-point FFT pipeline
package fft_pkg;
   localparam int FFT_POINTS = 32;
   localparam int FFT_STAGES = $clog2(FFT_POINTS);
   localparam int DATA_W     = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } fft_state_e;
endpackage

// File: rtl/fft_vld_slot.sv
// rtl/fft_vld_slot.sv - one elastic valid bit guarding a single datapath register
module fft_vld_slot (
   input  logic clk,
   input  logic rst,
   input  logic vld_up_i,
   input  logic en_dn_i,
   output logic vld_o,
   output logic en_o,
   output logic load_o
);
   logic vld_q;
   logic vld_d;

   // A slot may advance when it is empty or its occupant can move on downstream.
   assign en_o   = !vld_q || en_dn_i;
   assign load_o = en_o && vld_up_i;
   assign vld_o  = vld_q;
   assign vld_d  = en_o ? vld_up_i : vld_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_q <= 1'b0;
      end else begin
         vld_q <= vld_d;
      end
   end
endmodule

// File: rtl/fft_pipe_ctrl.sv
// rtl/fft_pipe_ctrl.sv - valid/ready sequencer for the FFT input and butterfly stage registers
module fft_pipe_ctrl
   import fft_pkg::*;
#(
   parameter  int STAGES = FFT_STAGES,
   parameter  int CNT_W  = 16,
   localparam int DEPTH  = STAGES + 1,
   localparam int OCC_W  = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   input  logic             flush,
   output logic [DEPTH-1:0] stage_load,
   output logic [OCC_W-1:0] occupancy,
   output logic [CNT_W-1:0] frame_cnt,
   output logic             busy,
   output logic             flush_done
);
   logic             accept;
   logic             deliver;
   fft_state_e       state_q, state_d;
   logic [OCC_W-1:0] occ_q, occ_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             flush_q;
   logic             flush_done_q, flush_done_d;

   // Each slot is chained through scalars in its own scope so the enable
   // ripple from the output back to the input stays an acyclic net chain.
   for (genvar k = 0; k < DEPTH; k++) begin : g_slot
      logic vld_w;
      logic en_w;
      logic up_w;
      logic dn_w;

      if (k == 0) begin : g_head
         assign up_w = accept;
      end else begin : g_body
         assign up_w = g_slot[k-1].vld_w;
      end

      if (k == DEPTH - 1) begin : g_tail
         assign dn_w = out_ready;
      end else begin : g_mid
         assign dn_w = g_slot[k+1].en_w;
      end

      fft_vld_slot u_slot (
         .clk      (clk),
         .rst      (rst),
         .vld_up_i (up_w),
         .en_dn_i  (dn_w),
         .vld_o    (vld_w),
         .en_o     (en_w),
         .load_o   (stage_load[k])
      );
   end

   // A pending or held flush request wins over a new frame in the same cycle.
   assign in_ready  = g_slot[0].en_w && (state_q != FLUSH) && !flush;
   assign accept    = in_valid && in_ready;
   assign out_valid = g_slot[DEPTH-1].vld_w;
   assign deliver   = out_valid && out_ready;

   always_comb begin
      occ_d = occ_q;
      if (accept && !deliver) begin
         occ_d = occ_q + OCC_W'(1);
      end else if (!accept && deliver) begin
         occ_d = occ_q - OCC_W'(1);
      end
   end

   assign cnt_d = deliver ? cnt_q + CNT_W'(1) : cnt_q;

   always_comb begin
      state_d      = state_q;
      flush_done_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (flush) begin
               flush_done_d = !flush_q;
            end else if (accept) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (flush) begin
               state_d = FLUSH;
            end else if (occ_d == '0) begin
               state_d = IDLE;
            end
         end
         FLUSH: begin
            if (occ_d == '0) begin
               state_d      = IDLE;
               flush_done_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         occ_q        <= '0;
         cnt_q        <= '0;
         flush_q      <= 1'b0;
         flush_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         occ_q        <= occ_d;
         cnt_q        <= cnt_d;
         flush_q      <= flush;
         flush_done_q <= flush_done_d;
      end
   end

   assign occupancy  = occ_q;
   assign frame_cnt  = cnt_q;
   assign busy       = (state_q != IDLE);
   assign flush_done = flush_done_q;
endmodule

// File: doc/fft_pipe_ctrl.md
Name: fft_pipe_ctrl

Overview:
- Valid/ready sequencer for the 32-point DIT FFT datapath: an input register followed by one pipeline register per butterfly stage.
- Tracks which registers hold live frames and drives per-register load enables, so the datapath becomes an elastic pipeline with bubble collapse and output backpressure.
- Also provides flush, occupancy and output-frame-count status.
- Sits between the frame source/sink and the 32-lane stage registers; carries no sample data itself.

Parameters:
- STAGES, 5, number of butterfly stages (log2 of 32-point FFT).
- DEPTH, STAGES+1, localparam: total registers sequenced (input register plus one per stage).
- CNT_W, 16, width of the output frame counter.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  source presents a full 32-sample frame.
- in_ready  out  1  controller accepts the frame this cycle.
- out_valid  out  1  final register holds a valid FFT result.
- out_ready  in  1  sink takes the result this cycle.
- flush  in  1  level request: stop accepting, drain, return to IDLE.
- stage_load  out  DEPTH  bit k = load enable of datapath register k (bit 0 = input register).
- occupancy  out  $clog2(DEPTH+1)  number of valid frames in flight.
- frame_cnt  out  CNT_W  completed output handshakes, wrapping.
- busy  out  1  state != IDLE.
- flush_done  out  1  one-cycle pulse when a flush completes.

Behaviour:
- Reset (rst low, async): vld[*]=0, state=IDLE, occupancy=0, frame_cnt=0, flush_done=0. Consequently out_valid=0, stage_load=0, busy=0. in_ready=1 once rst is released.
- Internal valid vector vld[DEPTH-1:0] is registered.
- Combinational advance chain:
  - en[DEPTH-1] = !vld[DEPTH-1] | out_ready.
  - en[k] = !vld[k] | en[k+1].
- Handshakes:
  - in_ready = en[0] & (state != FLUSH); accept = in_valid & in_ready.
  - out_valid = vld[DEPTH-1]; deliver = out_valid & out_ready.
- stage_load:
  - stage_load[0] = accept.
  - stage_load[k] = en[k] & vld[k-1] for k>0.
  - Registers are never loaded with bubbles.
- Valid update per edge:
  - If en[0]: vld[0] <= accept.
  - If en[k]: vld[k] <= vld[k-1].
  - Otherwise vld[k] holds.
- Latency: accept in cycle t with out_ready held high gives out_valid in cycle t+DEPTH (6 at default). Throughput is 1 frame/cycle.
- Backpressure: out_ready low holds the last register. Upstream frames advance into bubbles. in_ready drops only when all DEPTH registers are valid.
- Simultaneous accept and deliver on a full pipeline is allowed: everything shifts, occupancy is unchanged.
- occupancy is a registered counter: +1 on accept, -1 on deliver, both means no change. It must always equal popcount(vld); a bench assertion checks this.
- frame_cnt increments on deliver and wraps 2^CNT_W-1 -> 0.
- FSM:
  - IDLE -> RUN on accept.
  - RUN -> IDLE when next occupancy is 0.
  - RUN -> FLUSH when flush=1. flush has priority over accept in the same cycle: in_ready is forced 0 that cycle.
  - FLUSH -> IDLE when next occupancy is 0; flush_done pulses in the first IDLE cycle.
  - flush in IDLE: stays IDLE, flush_done pulses next cycle, one pulse per rising edge of flush.
  - While flush stays high in IDLE, in_ready=0.
- Flush does not discard frames; they drain subject to out_ready.
- Reset mid-operation discards all in-flight frames immediately. Datapath contents are don't-care because vld is cleared.

Decomposition:
- Shared package fft_pkg holds: FFT_POINTS=32, FFT_STAGES=5, DATA_W=16, and the state encoding typedef (IDLE=2'd0, RUN=2'd1, FLUSH=2'd2).
- One natural sub-module: fft_vld_slot, a single elastic valid bit (inputs: upstream valid, downstream enable; outputs: vld, en, load), instantiated DEPTH times in a generate loop.

Test Plan:
- Reset then single frame, out_ready=1: accept at cycle 0 -> out_valid high only in cycle 6, stage_load one-hot walks bits 0..5, frame_cnt=1, busy falls after delivery.
- Back-to-back 10 frames, out_ready=1: in_ready stays 1, out_valid high cycles 6..15, occupancy peaks at 6, frame_cnt=10.
- Stream with out_ready=0 from cycle 3: in_ready drops after the 6th accept, occupancy=6, no stage_load on full registers. Raising out_ready -> delivery resumes next cycle, zero frames lost.
- Bubble collapse: accept frames at cycles 0 and 3 with out_ready=0 until cycle 10 -> frames compact into vld[5] and vld[4], both delivered in consecutive cycles.
- Flush with 4 in flight, out_ready=1: in_ready=0 immediately, 4 deliveries, flush_done one pulse in the first IDLE cycle, occupancy=0.
- Wrap and reset: preload frame_cnt near 0xFFFF via 65536 deliveries (or force) -> reads 0 after wrap; assert rst low mid-stream -> out_valid, occupancy, busy go 0 asynchronously.
